// File: rtl/uart_tx_arbiter.sv
//-----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares a single uart_tx byte serializer among NUM_REQ requesters. A
// round-robin arbiter grants one requester at a time, latches its
// WORD_BYTES-byte word and sends it as a framed packet:
//   header {HDR_TAG, grant index}, payload MSB byte first, optional checksum.
// Each byte is handed to uart_tx with a one-cycle start pulse; the next byte
// is only loaded after uart_tx reports done.
//
// Optional feature macro: TX_CHECKSUM_EN
//   defined   : one extra trailing byte = XOR of header and all payload bytes
//   undefined : no checksum byte and no XOR logic
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active-low
//   req_i          per-requester level request, held until its ack_o
//   req_data_i     requester words, word k at [k*WORD_BYTES*8 +: WORD_BYTES*8]
//   ack_o          one-hot single-cycle pulse: word k latched
//   busy_o         high from grant until the packet is complete
//   packet_done_o  single-cycle pulse after the last byte's tx_done_i
//   tx_data_o      byte presented to uart_tx
//   tx_start_o     single-cycle start pulse to uart_tx
//   tx_done_i      uart_tx end-of-frame pulse
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter int         WORD_BYTES = 4,
    parameter logic [3:0] HDR_TAG    = 4'hA
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data_i,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic                            busy_o,
    output logic                            packet_done_o,
    output logic [7:0]                      tx_data_o,
    output logic                            tx_start_o,
    input  logic                            tx_done_i
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef TX_CHECKSUM_EN
    localparam int LAST_IDX = WORD_BYTES + 1;
`else
    localparam int LAST_IDX = WORD_BYTES;
`endif
    localparam int IDX_W = $clog2(LAST_IDX + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_q, start_d;
    logic [7:0]           data_q, data_d;
`ifdef TX_CHECKSUM_EN
    logic [7:0]           cksum_q, cksum_d;
`endif

    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_vld;
    logic [7:0]           hdr_byte;
    logic                 last_byte;
    int                   cand;

    // Round-robin pick: scan from the farthest candidate to the nearest so
    // the requester closest to (at/after) the pointer is the final winner.
    always_comb begin
        grant_idx = ptr_q;
        grant_vld = 1'b0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_i[PTR_W'(cand)]) begin
                grant_idx = PTR_W'(cand);
                grant_vld = 1'b1;
            end
        end
    end

    assign hdr_byte  = {HDR_TAG, 4'(grant_idx)};
    assign last_byte = (idx_q == IDX_W'(LAST_IDX));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (tx_done_i) state_d = last_byte ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ack_d   = '0;
        done_d  = 1'b0;
        start_d = 1'b0;
        busy_d  = busy_q;
        data_d  = data_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
`ifdef TX_CHECKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ack_d  = NUM_REQ'(1) << grant_idx;
                    busy_d = 1'b1;
                    data_d = hdr_byte;
                    idx_d  = '0;
                    ptr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    word_d = req_data_i[int'(grant_idx)*WORD_W +: WORD_W];
`ifdef TX_CHECKSUM_EN
                    cksum_d = hdr_byte;
`endif
                end
            end
            START: begin
                start_d = 1'b1;
            end
            WAIT: begin
                if (tx_done_i) begin
                    if (last_byte) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
`ifdef TX_CHECKSUM_EN
                        if (idx_q == IDX_W'(WORD_BYTES)) begin
                            data_d = cksum_q;
                        end else begin
                            data_d  = word_q[WORD_W-1 -: 8];
                            word_d  = word_q << 8;
                            cksum_d = cksum_q ^ word_q[WORD_W-1 -: 8];
                        end
`else
                        // Payload leaves MSB byte first: shift the word up.
                        data_d = word_q[WORD_W-1 -: 8];
                        word_d = word_q << 8;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            data_q  <= data_d;
        end
    end

    // Latched word (and running checksum) are only read inside a packet.
    always_ff @(posedge clk) begin
        word_q  <= word_d;
`ifdef TX_CHECKSUM_EN
        cksum_q <= cksum_d;
`endif
    end

    assign ack_o         = ack_q;
    assign busy_o        = busy_q;
    assign packet_done_o = done_q;
    assign tx_start_o    = start_q;
    assign tx_data_o     = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int WORD_BYTES = 4;
    localparam int BAUD_CYC   = 33 * 10;
`ifdef TX_CHECKSUM_EN
    localparam int PKT_BYTES = WORD_BYTES + 2;
`else
    localparam int PKT_BYTES = WORD_BYTES + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_i = '0;
    logic [127:0] req_data_i = '0;
    logic [3:0]   ack_o;
    logic         busy_o, packet_done_o, tx_start_o, tx_done_i;
    logic [7:0]   tx_data_o;
    logic         mdl_done = 1'b0;
    logic         spur_done = 1'b0;

    assign tx_done_i = mdl_done | spur_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .WORD_BYTES(WORD_BYTES), .HDR_TAG(4'hA)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_data_i(req_data_i),
        .ack_o(ack_o), .busy_o(busy_o), .packet_done_o(packet_done_o),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ack_q[$];
    int exp_ack_q[$];
    int start_cnt, done_cnt, stab_err, wide_err, sbusy_err, ack_err, busy_err;
    int mptr = 0;

    // uart_tx stand-in plus protocol monitor
    bit uart_busy = 0, prev_start = 0, in_pkt = 0;
    int uart_cnt = 0;
    logic [7:0] uart_byte = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            uart_busy = 0; uart_cnt = 0; mdl_done = 1'b0; prev_start = 0; in_pkt = 0;
        end else begin
            mdl_done = 1'b0;
            if (uart_busy) begin
                if (tx_data_o !== uart_byte) stab_err++;
                uart_cnt--;
                if (uart_cnt == 0) begin
                    uart_busy = 0;
                    mdl_done = 1'b1;
                end
            end
            if (ack_o !== 4'b0) begin
                if (!$onehot(ack_o) || in_pkt) ack_err++;
                for (int k = 0; k < NUM_REQ; k++) if (ack_o[k]) ack_q.push_back(k);
                in_pkt = 1;
            end
            if (tx_start_o === 1'b1) begin
                if (prev_start) wide_err++;
                if (uart_busy || !in_pkt) sbusy_err++;
                start_cnt++;
                uart_byte = tx_data_o;
                got_q.push_back(tx_data_o);
                uart_busy = 1;
                uart_cnt = BAUD_CYC;
            end
            prev_start = (tx_start_o === 1'b1);
            if (packet_done_o === 1'b1) begin
                if (!in_pkt) ack_err++;
                done_cnt++;
                in_pkt = 0;
            end
            if (busy_o !== in_pkt) busy_err++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    // Reference model: round-robin choice and packet byte list
    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int c = (ptr + k) % NUM_REQ;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic expect_pkt(input int g, input logic [31:0] w);
        logic [7:0] h, x, b;
        h = {4'hA, 4'(g)};
        exp_q.push_back(h);
        x = h;
        for (int i = WORD_BYTES - 1; i >= 0; i--) begin
            b = w[i*8 +: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_ack_q.push_back(g);
        mptr = (g + 1) % NUM_REQ;
    endtask

    task automatic clear_mon();
        got_q.delete(); exp_q.delete(); ack_q.delete(); exp_ack_q.delete();
        start_cnt = 0; done_cnt = 0; stab_err = 0; wide_err = 0;
        sbusy_err = 0; ack_err = 0; busy_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; req_i = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1; mptr = 0;
        clear_mon();
    endtask

    // Requesters drop their request (and scramble their word) once acked.
    task automatic run_until(input int n_done, output bit ok);
        int c = 0;
        while (done_cnt < n_done && c < 20000) begin
            @(negedge clk); #1; c++;
            for (int k = 0; k < NUM_REQ; k++)
                if (ack_o[k]) begin
                    req_i[k] = 1'b0;
                    req_data_i[k*32 +: 32] = $urandom;
                end
        end
        ok = (done_cnt >= n_done);
    endtask

    task automatic test_reset();
        bit ok;
        logic [31:0] w;
        int c;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ack_o, busy_o, packet_done_o, tx_start_o, tx_data_o} !== 15'b0) begin
            failures++;
            $display("FAIL reset_init outputs=%h required=0", {ack_o, busy_o, packet_done_o, tx_start_o, tx_data_o});
        end
        rst_n = 1'b1; mptr = 0; clear_mon();
        // abort a packet mid-flight
        req_i = 4'b0010; req_data_i[63:32] = $urandom;
        c = 0;
        while (ack_o === 4'b0 && c < 10) begin @(negedge clk); #1; c++; end
        req_i = '0;
        repeat (150) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_o, busy_o, packet_done_o, tx_start_o, tx_data_o} !== 15'b0) begin
            failures++;
            $display("FAIL reset_async outputs=%h required=0", {ack_o, busy_o, packet_done_o, tx_start_o, tx_data_o});
        end
        @(negedge clk); #1;
        rst_n = 1'b1; mptr = 0; clear_mon();
        repeat (400) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || start_cnt != 0) begin
            failures++;
            $display("FAIL reset_abort done=%0d starts=%0d required 0/0", done_cnt, start_cnt);
        end
        // fresh request after release: grant 0, 2-cycle start latency
        w = $urandom;
        req_data_i[31:0] = w;
        req_i = 4'b0001;
        expect_pkt(rr_pick(4'b0001, mptr), w);
        @(negedge clk); #1;
        checks++;
        if (ack_o !== 4'b0001 || tx_data_o !== 8'hA0 || busy_o !== 1'b1 || tx_start_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant ack=%b data=%h busy=%b start=%b required 0001/a0/1/0", ack_o, tx_data_o, busy_o, tx_start_o);
        end
        req_i = '0;
        @(negedge clk); #1;
        checks++;
        if (tx_start_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_latency start=%b required=1", tx_start_o);
        end
        run_until(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_timeout done=%0d required=1", done_cnt); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL reset_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL reset_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        req_data_i[95:64] = 32'hDEADBEEF;
        expect_pkt(rr_pick(4'b0100, mptr), 32'hDEADBEEF);
        req_i = 4'b0100;
        run_until(1, ok);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout done=%0d required=1", done_cnt); end
        checks++;
        if (ack_q.size() != 1 || done_cnt != 1) begin
            failures++; $display("FAIL single_counts acks=%0d dones=%0d required 1/1", ack_q.size(), done_cnt);
        end else begin
            checks++;
            if (ack_q[0] != 2) begin failures++; $display("FAIL single_grant got=%0d required=2", ack_q[0]); end
        end
        checks++;
        if (start_cnt != PKT_BYTES) begin
            failures++; $display("FAIL single_starts got=%0d required=%0d", start_cnt, PKT_BYTES);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL single_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL single_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int c;
        logic [31:0] w[4];
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            w[k] = $urandom;
            req_data_i[k*32 +: 32] = w[k];
        end
        for (int n = 0; n < 5; n++) begin
            int g = rr_pick(4'b1111, mptr);
            expect_pkt(g, w[g]);
        end
        req_i = 4'b1111;
        c = 0;
        while (ack_q.size() < 5 && c < 20000) begin @(negedge clk); #1; c++; end
        req_i = '0;
        run_until(5, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_timeout done=%0d required=5", done_cnt); end
        checks++;
        if (ack_q.size() != exp_ack_q.size()) begin
            failures++; $display("FAIL rr_grants got=%0d required=%0d", ack_q.size(), exp_ack_q.size());
        end
        foreach (exp_ack_q[i]) if (i < ack_q.size()) begin
            checks++;
            if (ack_q[i] != exp_ack_q[i]) begin
                failures++; $display("FAIL rr_order%0d got=%0d required=%0d", i, ack_q[i], exp_ack_q[i]);
            end
        end
        checks++;
        if (start_cnt != 5 * PKT_BYTES) begin
            failures++; $display("FAIL rr_starts got=%0d required=%0d", start_cnt, 5 * PKT_BYTES);
        end
        checks++;
        if (stab_err + wide_err + sbusy_err + ack_err + busy_err != 0) begin
            failures++;
            $display("FAIL rr_protocol stab=%0d wide=%0d overlap=%0d ack=%0d busy=%0d required all 0",
                     stab_err, wide_err, sbusy_err, ack_err, busy_err);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rr_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL rr_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_checksum();
        bit ok;
        do_reset();
        req_data_i[31:0] = 32'h01020304;
        expect_pkt(rr_pick(4'b0001, mptr), 32'h01020304);
        req_i = 4'b0001;
        run_until(1, ok);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (!ok || done_cnt != 1) begin
            failures++; $display("FAIL cksum_done got=%0d required=1", done_cnt);
        end
        checks++;
        if (got_q.size() != PKT_BYTES) begin
            failures++; $display("FAIL cksum_len got=%0d required=%0d", got_q.size(), PKT_BYTES);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL cksum_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_spurious();
        bit ok;
        logic [31:0] w;
        int c;
        clear_mon();
        spur_done = 1'b1;
        @(negedge clk); #1;
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || start_cnt != 0) begin
            failures++; $display("FAIL spur_idle busy=%b starts=%0d required 0/0", busy_o, start_cnt);
        end
        w = $urandom;
        req_data_i[31:0] = w;
        expect_pkt(rr_pick(4'b0001, mptr), w);
        req_i = 4'b0001;
        c = 0;
        while (ack_o === 4'b0 && c < 10) begin @(negedge clk); #1; c++; end
        req_i = '0;
        spur_done = 1'b1;
        @(negedge clk); #1;
        spur_done = 1'b0;
        run_until(1, ok);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (!ok || done_cnt != 1 || start_cnt != PKT_BYTES) begin
            failures++;
            $display("FAIL spur_start dones=%0d starts=%0d required 1/%0d", done_cnt, start_cnt, PKT_BYTES);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL spur_len got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL spur_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 3; it++) begin
            logic [3:0] mask, pend;
            int n;
            clear_mon();
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < NUM_REQ; k++) req_data_i[k*32 +: 32] = $urandom;
            pend = mask; n = 0;
            while (pend != 4'b0) begin
                int g = rr_pick(pend, mptr);
                expect_pkt(g, req_data_i[g*32 +: 32]);
                pend[g] = 1'b0;
                n++;
            end
            req_i = mask;
            run_until(n, ok);
            repeat (5) @(negedge clk);
            #1;
            checks++;
            if (!ok || done_cnt != n) begin
                failures++; $display("FAIL rand%0d_done got=%0d required=%0d", it, done_cnt, n);
            end
            checks++;
            if (stab_err + wide_err + sbusy_err + ack_err + busy_err != 0) begin
                failures++;
                $display("FAIL rand%0d_protocol stab=%0d wide=%0d overlap=%0d ack=%0d busy=%0d required all 0",
                         it, stab_err, wide_err, sbusy_err, ack_err, busy_err);
            end
            foreach (exp_ack_q[i]) begin
                checks++;
                if (i >= ack_q.size() || ack_q[i] != exp_ack_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d_grant%0d got=%0d required=%0d", it, i,
                             (i < ack_q.size()) ? ack_q[i] : -1, exp_ack_q[i]);
                end
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_len got=%0d required=%0d", it, got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand%0d_byte%0d got=%h required=%h", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_round_robin();
        test_checksum();
        test_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
